inst_sequencer: RTL and testbench
=================================

// Module: inst_sequencer
// PURPOSE
//  Downstream consumer of the instruction buffer. Latches one 128-bit instruction per
//  init_inst_pulse, decodes it and runs a multi-cycle issue loop driving weight/activation/
//  output buffer strobes and systolic-array execute. Returns flag to the buffer: 1 = ready, 0 = busy.
// PARAMETERS
//  INST_BITS  128  instruction width
//  ADDR_BITS  10   buffer address width; addresses wrap mod 2^ADDR_BITS
//  CNT_BITS   16   burst-count width
// PORTS
//  clk              in   1          system clock; all state updates on rising edge
//  reset_n          in   1          asynchronous, active-low reset
//  instruction      in   INST_BITS  instruction word from instruction buffer
//  init_inst_pulse  in   1          1-cycle strobe: instruction valid this cycle
//  stall            in   1          downstream back-pressure; freezes ISSUE
//  exec_done        in   1          systolic array finished an EXEC burst
//  flag             out  1          1 = idle/ready for next instruction, 0 = busy
//  wbuf_rd          out  1          weight-buffer read strobe
//  abuf_rd          out  1          activation-buffer read strobe
//  obuf_wr          out  1          output-buffer write strobe
//  exec_start       out  1          1-cycle pulse starting array execute
//  src_addr         out  ADDR_BITS  current read address
//  dst_addr         out  ADDR_BITS  current write address
//  halted           out  1          sticky: HALT executed
//  err              out  1          sticky illegal-opcode flag (macro only; else tied 0)
// BEHAVIOUR
//  Format: [127:124] opcode, [123:114] src, [113:104] dst, [103:88] count, rest ignored.
//  Opcodes: 0 NOP, 1 LOAD_W (wbuf_rd), 2 LOAD_A (abuf_rd), 3 EXEC, 4 STORE (obuf_wr), F HALT.
//  Reset: state IDLE, flag=1, all strobes/addresses/halted/err = 0.
//  FSM IDLE -> DECODE -> ISSUE -> (WAIT_EXEC) -> DONE -> IDLE; HALT -> HALTED (absorbing).
//  IDLE: init_inst_pulse & !halted -> latch instruction, flag=0 from next cycle, go DECODE.
//  DECODE (1 cycle): load src/dst/count regs; NOP or count==0 -> DONE; HALT -> HALTED, halted=1.
//  ISSUE: each cycle with stall=0 assert op strobe, src/dst as current, then +1 (wrap),
//   remaining count -1; last beat when remaining==1. stall=1 -> strobes low, regs held.
//  EXEC: exec_start pulses once on first ISSUE cycle (count ignored), then WAIT_EXEC
//   until exec_done=1 (exec_done before exec_start ignored).
//  DONE (1 cycle): flag=1 next cycle, go IDLE. Pulse->flag fall latency 1 cycle;
//   minimum instruction turnaround 3 cycles (IDLE, DECODE, DONE).
//  init_inst_pulse while flag=0 or in HALTED: ignored, no latch.
//  HALTED: flag stays 0; exit only by reset.
//  reset_n low mid-burst: immediate abort, all outputs to reset values.
// CONFIGURATION
//  INST_SEQ_ILLEGAL_TRAP_EN defined: opcode 5..E in DECODE sets err=1 (sticky),
//   enters HALTED with halted=1.
//  Undefined: opcodes 5..E decode as NOP; err tied 0.
// TESTING
//  1 Reset: reset_n=0 mid-LOAD_W burst -> flag=1, wbuf_rd=0, src_addr=0 immediately.
//  2 LOAD_W src=0x010 count=4 -> wbuf_rd high 4 cycles, src 0x010..0x013, flag back to 1 after DONE.
//  3 STORE dst=0x3FE count=3 with stall=1 on 2nd beat 2 cycles -> dst 0x3FE,0x3FF,0x000;
//   obuf_wr low during stall; total 5 ISSUE cycles.
//  4 EXEC -> exec_start 1 pulse; exec_done after 20 cycles -> flag=1 two cycles later;
//   extra init_inst_pulse while busy ignored.
//  5 NOP and count=0 LOAD_A -> no strobes, flag low exactly 2 cycles.
//  6 HALT -> halted=1, flag stays 0, later pulses ignored; opcode 7: with macro err=1
//   and halted=1, without macro behaves as NOP.

Source files
------------

// File: rtl/inst_sequencer.sv
// Instruction sequencer: latches one instruction per init_inst_pulse and issues buffer strobes / array execute (option: INST_SEQ_ILLEGAL_TRAP_EN).
// Latency: flag falls 1 cycle after an accepted pulse; minimum turnaround is 3 cycles (IDLE, DECODE, DONE).
// Backpressure: stall freezes ISSUE (strobes low, address/count held); pulses while busy or halted are dropped.
module inst_sequencer #(
    parameter int INST_BITS = 128,
    parameter int ADDR_BITS = 10,
    parameter int CNT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [INST_BITS-1:0] instruction,
    input  logic                 init_inst_pulse,
    input  logic                 stall,
    input  logic                 exec_done,
    output logic                 flag,
    output logic                 wbuf_rd,
    output logic                 abuf_rd,
    output logic                 obuf_wr,
    output logic                 exec_start,
    output logic [ADDR_BITS-1:0] src_addr,
    output logic [ADDR_BITS-1:0] dst_addr,
    output logic                 halted,
    output logic                 err
);

    localparam int HDR_BITS = 4 + 2 * ADDR_BITS + CNT_BITS;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_LOAD_W = 4'h1;
    localparam logic [3:0] OP_LOAD_A = 4'h2;
    localparam logic [3:0] OP_EXEC   = 4'h3;
    localparam logic [3:0] OP_STORE  = 4'h4;
    localparam logic [3:0] OP_HALT   = 4'hF;

    typedef struct packed {
        logic [3:0]           op;
        logic [ADDR_BITS-1:0] src;
        logic [ADDR_BITS-1:0] dst;
        logic [CNT_BITS-1:0]  cnt;
    } hdr_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DECODE    = 3'd1,
        ISSUE     = 3'd2,
        WAIT_EXEC = 3'd3,
        DONE      = 3'd4,
        HALTED    = 3'd5
    } state_t;

    state_t               state_q, state_d;
    hdr_t                 hdr_q;
    logic [ADDR_BITS-1:0] src_q, dst_q;
    logic [CNT_BITS-1:0]  cnt_q;
    logic                 halted_q;

    logic accept;
    logic beat;
    logic is_burst_op;
    logic illegal_trap;
    logic halt_now;

    // Only the header bits carry meaning; the tail of the word is don't-care.
    logic unused_tail;
    assign unused_tail = ^instruction[INST_BITS-HDR_BITS-1:0];

    assign accept      = (state_q == IDLE) && init_inst_pulse && !halted_q;
    assign beat        = (state_q == ISSUE) && !stall;
    assign is_burst_op = (hdr_q.op == OP_LOAD_W) || (hdr_q.op == OP_LOAD_A) ||
                         (hdr_q.op == OP_STORE);

`ifdef INST_SEQ_ILLEGAL_TRAP_EN
    assign illegal_trap = (hdr_q.op >= 4'h5) && (hdr_q.op <= 4'hE);
`else
    assign illegal_trap = 1'b0;
`endif

    assign halt_now = (hdr_q.op == OP_HALT) || illegal_trap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (halt_now) begin
                    state_d = HALTED;
                end else if (hdr_q.op == OP_EXEC) begin
                    // EXEC ignores the count field and always issues once.
                    state_d = ISSUE;
                end else if (is_burst_op && (hdr_q.cnt != '0)) begin
                    state_d = ISSUE;
                end else begin
                    state_d = DONE;
                end
            end
            ISSUE: begin
                if (beat) begin
                    if (hdr_q.op == OP_EXEC) begin
                        state_d = WAIT_EXEC;
                    end else if (cnt_q <= CNT_BITS'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            WAIT_EXEC: begin
                if (exec_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hdr_q    <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            if (accept) begin
                hdr_q <= instruction[INST_BITS-1 -: HDR_BITS];
            end
            if (state_q == DECODE) begin
                src_q <= hdr_q.src;
                dst_q <= hdr_q.dst;
                cnt_q <= hdr_q.cnt;
                if (halt_now) begin
                    halted_q <= 1'b1;
                end
            end else if (beat && (hdr_q.op != OP_EXEC)) begin
                // Addresses wrap naturally at 2^ADDR_BITS.
                src_q <= src_q + 1'b1;
                dst_q <= dst_q + 1'b1;
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

`ifdef INST_SEQ_ILLEGAL_TRAP_EN
    logic err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if ((state_q == DECODE) && illegal_trap) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Strobes are combinational so stall drops them in the same cycle.
    assign flag       = (state_q == IDLE);
    assign wbuf_rd    = beat && (hdr_q.op == OP_LOAD_W);
    assign abuf_rd    = beat && (hdr_q.op == OP_LOAD_A);
    assign obuf_wr    = beat && (hdr_q.op == OP_STORE);
    assign exec_start = beat && (hdr_q.op == OP_EXEC);
    assign src_addr   = src_q;
    assign dst_addr   = dst_q;
    assign halted     = halted_q;

    logic unused_nop;
    assign unused_nop = (hdr_q.op == OP_NOP);

endmodule

// File: tb/tb_inst_sequencer.sv
module tb_inst_sequencer;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [127:0] instruction;
    logic         init_inst_pulse;
    logic         stall;
    logic         exec_done;
    logic         flag, wbuf_rd, abuf_rd, obuf_wr, exec_start, halted, err;
    logic [9:0]   src_addr, dst_addr;

    always #5 clk = ~clk;

    inst_sequencer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .instruction     (instruction),
        .init_inst_pulse (init_inst_pulse),
        .stall           (stall),
        .exec_done       (exec_done),
        .flag            (flag),
        .wbuf_rd         (wbuf_rd),
        .abuf_rd         (abuf_rd),
        .obuf_wr         (obuf_wr),
        .exec_start      (exec_start),
        .src_addr        (src_addr),
        .dst_addr        (dst_addr),
        .halted          (halted),
        .err             (err)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] op;
        logic [9:0] src;
        logic [9:0] dst;
    } beat_t;

    beat_t exp_q[$];
    bit    mon_en = 1'b0;
    int    exec_cnt = 0;
    int    mon_n;
    beat_t mon_got, mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [9:0] src, input logic [9:0] dst,
                         input logic [15:0] cnt);
        logic [95:0] junk;
        junk = {$urandom(), $urandom(), $urandom()};
        instruction = {op, src, dst, cnt, junk[87:0]};
    endtask

    task automatic push_beats(input logic [3:0] op, input logic [9:0] src, input logic [9:0] dst,
                              input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.op  = op;
            b.src = src + 10'(i);
            b.dst = dst + 10'(i);
            exp_q.push_back(b);
        end
    endtask

    // Issues one instruction from IDLE and measures how many cycles flag stays low.
    task automatic run_inst(input logic [3:0] op, input logic [9:0] src, input logic [9:0] dst,
                            input logic [15:0] cnt, input int nbeats, output int busy);
        push_beats(op, src, dst, nbeats);
        drive(op, src, dst, cnt);
        init_inst_pulse = 1'b1;
        @(negedge clk);
        check("flag_ready_before_pulse", flag, 1);
        step();
        init_inst_pulse = 1'b0;
        busy = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (flag) break;
            busy++;
            step();
        end
        step();
    endtask

    // Scoreboard: every strobe beat pops the next expected {op, src, dst}.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exec_start) exec_cnt++;
            mon_n = int'(wbuf_rd) + int'(abuf_rd) + int'(obuf_wr);
            if (mon_n > 1) begin
                check("strobes_onehot", mon_n, 1);
            end else if (mon_n == 1) begin
                mon_got.op  = wbuf_rd ? 4'h1 : (abuf_rd ? 4'h2 : 4'h4);
                mon_got.src = src_addr;
                mon_got.dst = dst_addr;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat_op", mon_got.op, 0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("beat", mon_got, mon_exp);
                end
            end
        end
    end

    typedef struct {
        logic [3:0]  op;
        logic [9:0]  src;
        logic [9:0]  dst;
        logic [15:0] cnt;
        int          exp_busy;
        int          exp_beats;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int busy;

        vecs[0] = '{4'h1, 10'h010, 10'h000, 16'd4, 6, 4};
        vecs[1] = '{4'h2, 10'h3FD, 10'h123, 16'd5, 7, 5};
        vecs[2] = '{4'h4, 10'h055, 10'h3FE, 16'd2, 4, 2};
        vecs[3] = '{4'h0, 10'h0AA, 10'h0BB, 16'd7, 2, 0};
        vecs[4] = '{4'h2, 10'h001, 10'h002, 16'd0, 2, 0};
        vecs[5] = '{4'h1, 10'h3FF, 10'h3FF, 16'd1, 3, 1};
        vecs[6] = '{4'h4, 10'h200, 10'h201, 16'd0, 2, 0};

        reset_n         = 1'b1;
        instruction     = '0;
        init_inst_pulse = 1'b0;
        stall           = 1'b0;
        exec_done       = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("reset_flag", flag, 1);
        check("reset_strobes", {wbuf_rd, abuf_rd, obuf_wr, exec_start}, 0);
        check("reset_src", src_addr, 0);
        check("reset_dst", dst_addr, 0);
        check("reset_halted", halted, 0);
        check("reset_err", err, 0);
        step();
        step();
        reset_n = 1'b1;
        mon_en  = 1'b1;
        step();

        for (int v = 0; v < 7; v++) begin
            run_inst(vecs[v].op, vecs[v].src, vecs[v].dst, vecs[v].cnt, vecs[v].exp_beats, busy);
            check($sformatf("vec%0d_busy_cycles", v), busy, vecs[v].exp_busy);
            check($sformatf("vec%0d_beats_drained", v), exp_q.size(), 0);
        end

        // STORE across the address wrap with a 2-cycle stall on the second beat.
        push_beats(4'h4, 10'h100, 10'h3FE, 3);
        drive(4'h4, 10'h100, 10'h3FE, 16'd3);
        init_inst_pulse = 1'b1;
        step();
        init_inst_pulse = 1'b0;
        busy = 0;
        for (int c = 1; c <= 8; c++) begin
            stall = (c == 3) || (c == 4);
            @(negedge clk);
            if (!flag) busy++;
            if (stall) begin
                check("stall_obuf_wr_low", obuf_wr, 0);
                check("stall_dst_held", dst_addr, 10'h3FF);
            end
            step();
        end
        stall = 1'b0;
        check("stall_busy_cycles", busy, 7);
        check("stall_beats_drained", exp_q.size(), 0);

        // EXEC: early exec_done and a busy-time pulse must both be ignored.
        exec_cnt = 0;
        drive(4'h3, 10'h000, 10'h000, 16'd9);
        init_inst_pulse = 1'b1;
        step();
        init_inst_pulse = 1'b0;
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        for (int c = 2; c < 22; c++) begin
            init_inst_pulse = (c == 5);
            if (c == 5) drive(4'h1, 10'h040, 10'h050, 16'd3);
            @(negedge clk);
            if (c == 2 || c == 10 || c == 21) check($sformatf("exec_busy_c%0d", c), flag, 0);
            step();
        end
        init_inst_pulse = 1'b0;
        exec_done = 1'b1;
        @(negedge clk);
        check("exec_done_cycle_flag", flag, 0);
        step();
        exec_done = 1'b0;
        @(negedge clk);
        check("exec_done_plus1_flag", flag, 0);
        step();
        @(negedge clk);
        check("exec_done_plus2_flag", flag, 1);
        check("exec_start_pulses", exec_cnt, 1);
        step();

        // Reset in the middle of a LOAD_W burst.
        push_beats(4'h1, 10'h0AB, 10'h0CD, 10);
        drive(4'h1, 10'h0AB, 10'h0CD, 16'd10);
        init_inst_pulse = 1'b1;
        step();
        init_inst_pulse = 1'b0;
        for (int c = 1; c < 5; c++) step();
        check("mid_burst_wbuf_rd", wbuf_rd, 1);
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("abort_flag", flag, 1);
        check("abort_wbuf_rd", wbuf_rd, 0);
        check("abort_src", src_addr, 0);
        check("abort_dst", dst_addr, 0);
        exp_q.delete();
        step();
        reset_n = 1'b1;
        mon_en  = 1'b1;
        step();

        // Opcode 7: trap or NOP depending on build.
`ifdef INST_SEQ_ILLEGAL_TRAP_EN
        drive(4'h7, 10'h001, 10'h002, 16'd5);
        init_inst_pulse = 1'b1;
        step();
        init_inst_pulse = 1'b0;
        step();
        @(negedge clk);
        check("illegal_err", err, 1);
        check("illegal_halted", halted, 1);
        check("illegal_flag", flag, 0);
        step();
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("illegal_reset_err", err, 0);
        step();
        reset_n = 1'b1;
        mon_en  = 1'b1;
        step();
`else
        run_inst(4'h7, 10'h001, 10'h002, 16'd5, 0, busy);
        check("op7_nop_busy", busy, 2);
        check("op7_err", err, 0);
        check("op7_halted", halted, 0);
`endif

        // HALT is absorbing until reset.
        drive(4'hF, 10'h000, 10'h000, 16'd0);
        init_inst_pulse = 1'b1;
        step();
        init_inst_pulse = 1'b0;
        step();
        @(negedge clk);
        check("halt_halted", halted, 1);
        check("halt_flag", flag, 0);
        step();
        drive(4'h1, 10'h010, 10'h020, 16'd2);
        for (int c = 0; c < 6; c++) begin
            init_inst_pulse = (c == 1);
            @(negedge clk);
            if (c == 5) begin
                check("halted_sticky", halted, 1);
                check("halted_flag_low", flag, 0);
            end
            step();
        end
        init_inst_pulse = 1'b0;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("halt_exit_halted", halted, 0);
        check("halt_exit_flag", flag, 1);
        step();
        reset_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
